// File: rtl/ft_fifo_device_model_if.sv
// Control, status and host-stream signals of the FT60x 245-style FIFO device model.
// The shared data/byte-enable bus stays on plain inout ports of the device model.
interface ft_fifo_device_model_if #(
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic [DATA_W-1:0] i_h2f_data;
    logic              i_h2f_valid;
    logic              o_h2f_ready;
    logic [DATA_W-1:0] o_f2h_data;
    logic [BE_W-1:0]   o_f2h_be;
    logic              o_f2h_valid;
    logic [23:0]       o_wr_count;
    logic              i_txe_hold;
    logic              o_ft_rxf_n;
    logic              o_ft_txe_n;
    logic              i_ft_oe_n;
    logic              i_ft_rd_n;
    logic              i_ft_wr_n;
    logic [2:0]        o_err;

    // Device side: the FT60x model.
    modport slave (
        input  i_h2f_data, i_h2f_valid, i_txe_hold,
        input  i_ft_oe_n, i_ft_rd_n, i_ft_wr_n,
        output o_h2f_ready, o_f2h_data, o_f2h_be, o_f2h_valid,
        output o_wr_count, o_ft_rxf_n, o_ft_txe_n, o_err
    );

    // Host/FPGA side driving the model.
    modport master (
        output i_h2f_data, i_h2f_valid, i_txe_hold,
        output i_ft_oe_n, i_ft_rd_n, i_ft_wr_n,
        input  o_h2f_ready, o_f2h_data, o_f2h_be, o_f2h_valid,
        input  o_wr_count, o_ft_rxf_n, o_ft_txe_n, o_err
    );
endinterface

// File: rtl/ft_fifo_device_model.sv
// FT60x chip-side model of the 16-bit 245-style synchronous FIFO interface.
// Host-to-FPGA words are queued in a small FIFO and presented on the bus while
// OE_n is low; FPGA-to-host writes are captured and streamed out to the host.
// TXE_n is paced by a burst/gap state machine and can be held off by the host.
module ft_fifo_device_model #(
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int RX_DEPTH = 16,
    parameter int TX_BURST = 256,
    parameter int TX_GAP   = 8
) (
    input  logic                  i_ft_clk,
    input  logic                  rst,
    inout  wire  [DATA_W-1:0]     io_ft_data,
    inout  wire  [BE_W-1:0]       io_ft_be,
    ft_fifo_device_model_if.slave bus_if
);
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = $clog2(RX_DEPTH + 1);
    localparam int BW = $clog2(TX_BURST + 1);
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    typedef enum logic [0:0] {
        TX_READY = 1'b0,
        TX_PAUSE = 1'b1
    } tx_state_t;

    // FIFO storage and control
    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rxf_n_q;

    // Write capture
    logic [DATA_W-1:0] f2h_data_q;
    logic [BE_W-1:0]   f2h_be_q;
    logic              f2h_valid_q;
    logic [23:0]       wr_count_q;
    logic [2:0]        err_q;

    // TXE pacing
    tx_state_t         tx_state_q;
    logic [BW-1:0]     burst_q;
    logic [GW-1:0]     gap_q;
    logic              txe_n_q;

    // Decoded strobes
    logic              empty_s;
    logic              not_full_s;
    logic              pop_req_s;
    logic              pop_s;
    logic              push_s;
    logic              wr_req_s;
    logic              capture_s;
    logic              contention_s;
    logic              overrun_s;
    logic              underrun_s;
    logic [BW-1:0]     burst_inc_s;
    logic              burst_hit_s;
    logic [DATA_W-1:0] head_s;
    logic              drive_s;

    // Decode bus strobes into FIFO/capture events and next pointer/count values.
    always_comb begin
        empty_s      = (count_q == CW'(0));
        not_full_s   = (count_q < CW'(RX_DEPTH));
        pop_req_s    = ~bus_if.i_ft_oe_n & ~bus_if.i_ft_rd_n;
        pop_s        = pop_req_s & ~empty_s;
        // A push into a full FIFO still lands when the same edge frees a slot.
        push_s       = bus_if.i_h2f_valid & (not_full_s | pop_s);
        wr_req_s     = ~bus_if.i_ft_wr_n;
        capture_s    = wr_req_s & ~txe_n_q & bus_if.i_ft_oe_n;
        contention_s = wr_req_s & ~bus_if.i_ft_oe_n;
        overrun_s    = wr_req_s & txe_n_q;
        underrun_s   = pop_req_s & empty_s;
        burst_inc_s  = burst_q + BW'(1);
        burst_hit_s  = capture_s & (burst_inc_s == BW'(TX_BURST));
        // Bus is released the instant reset asserts, independent of the clock.
        drive_s      = ~bus_if.i_ft_oe_n & ~rst;
        if (empty_s) begin
            head_s = {DATA_W{1'b0}};
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    assign io_ft_data = drive_s ? head_s : {DATA_W{1'bz}};
    assign io_ft_be   = drive_s ? {BE_W{1'b1}} : {BE_W{1'bz}};

    // FIFO storage write port; contents are don't-care after reset.
    always_ff @(posedge i_ft_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus_if.i_h2f_data;
        end
    end

    // FIFO pointers, occupancy and the registered RXF_n flag.
    always_ff @(posedge i_ft_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            rxf_n_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rxf_n_q  <= (count_d == CW'(0));
        end
    end

    // Capture FPGA writes, count them (saturating) and latch sticky errors.
    always_ff @(posedge i_ft_clk or posedge rst) begin
        if (rst) begin
            f2h_data_q  <= {DATA_W{1'b0}};
            f2h_be_q    <= {BE_W{1'b0}};
            f2h_valid_q <= 1'b0;
            wr_count_q  <= 24'd0;
            err_q       <= 3'b000;
        end else begin
            f2h_valid_q <= capture_s;
            if (capture_s) begin
                f2h_data_q <= io_ft_data;
                f2h_be_q   <= io_ft_be;
                if (wr_count_q != 24'hFF_FFFF) begin
                    wr_count_q <= wr_count_q + 24'd1;
                end
            end
            err_q <= err_q | {contention_s, overrun_s, underrun_s};
        end
    end

    // TXE_n pacing: accept TX_BURST words, then hold TXE_n high for TX_GAP cycles.
    always_ff @(posedge i_ft_clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_READY;
            burst_q    <= BW'(0);
            gap_q      <= GW'(0);
            txe_n_q    <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_READY: begin
                    if (burst_hit_s && (TX_GAP > 0)) begin
                        tx_state_q <= TX_PAUSE;
                        gap_q      <= GW'(TX_GAP);
                        burst_q    <= burst_inc_s;
                        txe_n_q    <= 1'b1;
                    end else if (burst_hit_s) begin
                        // No gap configured: just restart the burst count.
                        burst_q <= BW'(0);
                        txe_n_q <= bus_if.i_txe_hold;
                    end else if (capture_s) begin
                        burst_q <= burst_inc_s;
                        txe_n_q <= bus_if.i_txe_hold;
                    end else begin
                        txe_n_q <= bus_if.i_txe_hold;
                    end
                end
                TX_PAUSE: begin
                    // Countdown runs regardless of host hold.
                    if (gap_q <= GW'(1)) begin
                        tx_state_q <= TX_READY;
                        gap_q      <= GW'(0);
                        burst_q    <= BW'(0);
                        txe_n_q    <= bus_if.i_txe_hold;
                    end else begin
                        gap_q   <= gap_q - GW'(1);
                        txe_n_q <= 1'b1;
                    end
                end
                default: begin
                    tx_state_q <= TX_READY;
                    gap_q      <= GW'(0);
                    burst_q    <= BW'(0);
                    txe_n_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus_if.o_h2f_ready = not_full_s;
    assign bus_if.o_f2h_data  = f2h_data_q;
    assign bus_if.o_f2h_be    = f2h_be_q;
    assign bus_if.o_f2h_valid = f2h_valid_q;
    assign bus_if.o_wr_count  = wr_count_q;
    assign bus_if.o_ft_rxf_n  = rxf_n_q;
    assign bus_if.o_ft_txe_n  = txe_n_q;
    assign bus_if.o_err       = err_q;
endmodule
